// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared state type and sizing helper for the configuration chain loader
package config_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } cfg_state_t;

    function automatic int num_words(input int config_width, input int word_width);
        return (config_width + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/config_loader.sv
// rtl/config_loader.sv - fetches bitstream words and shifts them LSB-first into a serial configuration chain
module config_loader
    import config_pkg::*;
#(
    parameter int CONFIG_WIDTH = 40,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                  config_clk,
    input  logic                  config_rst_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_data,
    output logic                  chain_en,
    output logic                  busy,
    output logic                  done
);

    localparam int TW = $clog2(CONFIG_WIDTH + 1);
    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam logic [TW-1:0] TOTAL_LAST = TW'(CONFIG_WIDTH);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_WIDTH);

    cfg_state_t            state, next_state;
    logic [WORD_WIDTH-1:0] shreg, shreg_shifted;
    logic [TW-1:0]         total_cnt, total_inc;
    logic [BW-1:0]         bit_cnt, bit_inc;
    logic                  accept;

    assign accept        = (state == FETCH) && word_valid && word_ready;
    assign total_inc     = total_cnt + TW'(1);
    assign bit_inc       = bit_cnt + BW'(1);
    assign shreg_shifted = shreg >> 1;

    // The total limit wins over the word limit, which drops the unused top of the last word.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = FETCH;
            FETCH: if (accept) next_state = SHIFT;
            SHIFT: begin
                if (total_inc == TOTAL_LAST)  next_state = DONE;
                else if (bit_inc == BIT_LAST) next_state = FETCH;
            end
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) state <= IDLE;
        else               state <= next_state;
    end

    // Outputs are registered from next_state so they line up with the state they describe;
    // chain_data is a registered copy of shreg[0] for every SHIFT cycle.
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            word_ready <= 1'b0;
            chain_en   <= 1'b0;
            chain_data <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            total_cnt  <= '0;
        end else begin
            word_ready <= (next_state == FETCH);
            chain_en   <= (next_state == SHIFT);
            busy       <= (next_state != IDLE);
            done       <= (next_state == DONE);
            if (state == IDLE && start) total_cnt <= '0;
            if (accept) begin
                shreg      <= word_data;
                bit_cnt    <= '0;
                chain_data <= word_data[0];
            end else if (state == SHIFT) begin
                shreg     <= shreg_shifted;
                bit_cnt   <= bit_inc;
                total_cnt <= total_inc;
                if (next_state == SHIFT) chain_data <= shreg_shifted[0];
            end
        end
    end

endmodule
